// File: rtl/stage_decode_pipe_if.sv
// Decode-stage bundle: IF/ID inputs, writeback and EX/MEM feedback,
// fetch control and the registered ID/EX outputs.
interface stage_decode_pipe_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [31:0]       i_pc;
  logic [31:0]       i_instruction;
  logic              i_valid;
  logic              i_wb_we;
  logic [4:0]        i_wb_addr;
  logic [DATA_W-1:0] i_wb_data;
  logic              i_exmem_regwrite;
  logic              i_exmem_memread;
  logic [4:0]        i_exmem_rd;
  logic [DATA_W-1:0] i_exmem_data;
  logic              i_hold;
  logic              o_pc_write;
  logic              o_if_id_write;
  logic              o_if_id_flush;
  logic              o_pc_src;
  logic [31:0]       o_target;
  logic              o_ex_valid;
  logic              o_ex_regwrite;
  logic              o_ex_memread;
  logic              o_ex_memwrite;
  logic              o_ex_memtoreg;
  logic              o_ex_alusrc;
  logic [3:0]        o_ex_aluop;
  logic [DATA_W-1:0] o_ex_rs_val;
  logic [DATA_W-1:0] o_ex_rt_val;
  logic [DATA_W-1:0] o_ex_imm;
  logic [4:0]        o_ex_rs;
  logic [4:0]        o_ex_rt;
  logic [4:0]        o_ex_dst;
  logic [CNT_W-1:0]  o_stall_count;

  modport slave (
    input  i_pc, i_instruction, i_valid,
    input  i_wb_we, i_wb_addr, i_wb_data,
    input  i_exmem_regwrite, i_exmem_memread,
    input  i_exmem_rd, i_exmem_data, i_hold,
    output o_pc_write, o_if_id_write, o_if_id_flush,
    output o_pc_src, o_target,
    output o_ex_valid, o_ex_regwrite, o_ex_memread,
    output o_ex_memwrite, o_ex_memtoreg, o_ex_alusrc,
    output o_ex_aluop, o_ex_rs_val, o_ex_rt_val, o_ex_imm,
    output o_ex_rs, o_ex_rt, o_ex_dst, o_stall_count
  );

  modport master (
    output i_pc, i_instruction, i_valid,
    output i_wb_we, i_wb_addr, i_wb_data,
    output i_exmem_regwrite, i_exmem_memread,
    output i_exmem_rd, i_exmem_data, i_hold,
    input  o_pc_write, o_if_id_write, o_if_id_flush,
    input  o_pc_src, o_target,
    input  o_ex_valid, o_ex_regwrite, o_ex_memread,
    input  o_ex_memwrite, o_ex_memtoreg, o_ex_alusrc,
    input  o_ex_aluop, o_ex_rs_val, o_ex_rt_val, o_ex_imm,
    input  o_ex_rs, o_ex_rt, o_ex_dst, o_stall_count
  );
endinterface

// File: rtl/stage_decode_pipe.sv
// Instruction decode stage: register file, hazard detection,
// branch resolution with EX/MEM forwarding, and the ID/EX register.
module stage_decode_pipe #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             i_reset,
  stage_decode_pipe_if.slave bus
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [DATA_W-1:0] rf [NREGS];

  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [AW-1:0] rs_i, rt_i, wb_i;
  logic [DATA_W-1:0] rs_rf, rt_rf, rs_br, rt_br, imm;
  logic [31:0] imm32, br_target, j_target;
  logic unused_bits;

  assign instr = bus.i_instruction;
  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];
  assign rs_i  = rs[AW-1:0];
  assign rt_i  = rt[AW-1:0];
  assign wb_i  = bus.i_wb_addr[AW-1:0];
  assign imm   = {{(DATA_W-16){instr[15]}}, instr[15:0]};
  assign imm32 = {{16{instr[15]}}, instr[15:0]};
  assign unused_bits = ^{instr[10:6], imm32[31:30]};

  // Register reads with same-cycle writeback bypass; r0 is hardwired
  assign rs_rf = (rs_i == '0) ? '0 :
                 (bus.i_wb_we && wb_i == rs_i) ? bus.i_wb_data :
                 rf[rs_i];
  assign rt_rf = (rt_i == '0) ? '0 :
                 (bus.i_wb_we && wb_i == rt_i) ? bus.i_wb_data :
                 rf[rt_i];

  // Branch comparands take a completed ALU result from EX/MEM
  assign rs_br = (bus.i_exmem_regwrite && !bus.i_exmem_memread &&
                  rs != 5'd0 && bus.i_exmem_rd == rs) ?
                 bus.i_exmem_data : rs_rf;
  assign rt_br = (bus.i_exmem_regwrite && !bus.i_exmem_memread &&
                  rt != 5'd0 && bus.i_exmem_rd == rt) ?
                 bus.i_exmem_data : rt_rf;

  assign br_target = bus.i_pc + {imm32[29:0], 2'b00};
  assign j_target  = {bus.i_pc[31:28], instr[25:0], 2'b00};

  // Register file storage; reset clears every entry
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (bus.i_wb_we && wb_i != '0) begin
      rf[wb_i] <= bus.i_wb_data;
    end
  end

  logic is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j;
  logic dc_valid, dc_regwrite, dc_memread, dc_memwrite;
  logic dc_memtoreg, dc_alusrc, uses_rt;
  logic [3:0] dc_aluop;
  logic [4:0] dc_dst;

  assign is_r    = (op == 6'h00);
  assign is_addi = (op == 6'h08);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_bne  = (op == 6'h05);
  assign is_j    = (op == 6'h02);
  assign uses_rt = is_r | is_sw | is_beq | is_bne;

  // Opcode/funct decode into ID/EX controls; unknown opcodes become bubbles
  always_comb begin
    dc_valid    = 1'b0;
    dc_regwrite = 1'b0;
    dc_memread  = 1'b0;
    dc_memwrite = 1'b0;
    dc_memtoreg = 1'b0;
    dc_alusrc   = 1'b0;
    dc_aluop    = 4'h0;
    dc_dst      = 5'd0;
    unique case (1'b1)
      is_r: begin
        dc_valid    = 1'b1;
        dc_regwrite = 1'b1;
        dc_dst      = rd;
        unique case (funct)
          6'h20:   dc_aluop = 4'h0;
          6'h22:   dc_aluop = 4'h1;
          6'h24:   dc_aluop = 4'h2;
          6'h25:   dc_aluop = 4'h3;
          6'h2A:   dc_aluop = 4'h4;
          default: begin
            dc_aluop    = 4'hF;
            dc_regwrite = 1'b0;
          end
        endcase
      end
      is_addi: begin
        dc_valid    = 1'b1;
        dc_regwrite = 1'b1;
        dc_alusrc   = 1'b1;
        dc_dst      = rt;
      end
      is_lw: begin
        dc_valid    = 1'b1;
        dc_regwrite = 1'b1;
        dc_memread  = 1'b1;
        dc_memtoreg = 1'b1;
        dc_alusrc   = 1'b1;
        dc_dst      = rt;
      end
      is_sw: begin
        dc_valid    = 1'b1;
        dc_memwrite = 1'b1;
        dc_alusrc   = 1'b1;
      end
      default: dc_valid = 1'b0;
    endcase
  end

  logic lu_hit, br_hit, stall, taken;

  // Hazard detection, branch resolution and fetch steering
  always_comb begin
    lu_hit = bus.o_ex_valid && bus.o_ex_memread &&
             bus.o_ex_rt != 5'd0 &&
             (bus.o_ex_rt == rs || (uses_rt && bus.o_ex_rt == rt));
    br_hit = (is_beq || is_bne) && (
      (rs != 5'd0 &&
       ((bus.o_ex_regwrite && bus.o_ex_dst == rs) ||
        (bus.i_exmem_memread && bus.i_exmem_rd == rs))) ||
      (rt != 5'd0 &&
       ((bus.o_ex_regwrite && bus.o_ex_dst == rt) ||
        (bus.i_exmem_memread && bus.i_exmem_rd == rt))));
    stall = bus.i_valid && (lu_hit || br_hit);
    taken = bus.i_valid && !stall && (is_j ||
            (is_beq && rs_br == rt_br) ||
            (is_bne && rs_br != rt_br));
    bus.o_target      = is_j ? j_target : br_target;
    bus.o_pc_write    = 1'b1;
    bus.o_if_id_write = 1'b1;
    bus.o_pc_src      = taken;
    bus.o_if_id_flush = taken;
    if (bus.i_hold) begin
      bus.o_pc_write    = 1'b0;
      bus.o_if_id_write = 1'b0;
      bus.o_pc_src      = 1'b0;
      bus.o_if_id_flush = 1'b0;
    end else if (stall) begin
      bus.o_pc_write    = 1'b0;
      bus.o_if_id_write = 1'b0;
    end
  end

  logic load_real;
  assign load_real = bus.i_valid && dc_valid && !stall;

  // ID/EX register: frozen by hold, bubbled on stall/branch/invalid
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      bus.o_ex_valid    <= 1'b0;
      bus.o_ex_regwrite <= 1'b0;
      bus.o_ex_memread  <= 1'b0;
      bus.o_ex_memwrite <= 1'b0;
      bus.o_ex_memtoreg <= 1'b0;
      bus.o_ex_alusrc   <= 1'b0;
      bus.o_ex_aluop    <= 4'h0;
      bus.o_ex_rs_val   <= '0;
      bus.o_ex_rt_val   <= '0;
      bus.o_ex_imm      <= '0;
      bus.o_ex_rs       <= 5'd0;
      bus.o_ex_rt       <= 5'd0;
      bus.o_ex_dst      <= 5'd0;
    end else if (!bus.i_hold) begin
      bus.o_ex_valid    <= load_real;
      bus.o_ex_regwrite <= load_real & dc_regwrite;
      bus.o_ex_memread  <= load_real & dc_memread;
      bus.o_ex_memwrite <= load_real & dc_memwrite;
      bus.o_ex_memtoreg <= load_real & dc_memtoreg;
      bus.o_ex_alusrc   <= load_real & dc_alusrc;
      bus.o_ex_aluop    <= load_real ? dc_aluop : 4'h0;
      bus.o_ex_rs_val   <= rs_rf;
      bus.o_ex_rt_val   <= rt_rf;
      bus.o_ex_imm      <= imm;
      bus.o_ex_rs       <= rs;
      bus.o_ex_rt       <= rt;
      bus.o_ex_dst      <= load_real ? dc_dst : 5'd0;
    end
  end

  // Saturating count of cycles lost to stalls
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      bus.o_stall_count <= '0;
    end else if (stall && !bus.i_hold && bus.o_stall_count != '1) begin
      bus.o_stall_count <= bus.o_stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_stage_decode_pipe.sv
// Directed checks of the decode stage: bypass, hazards, branches,
// hold, reset and stall-counter saturation.
module tb_stage_decode_pipe;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  stage_decode_pipe_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  stage_decode_pipe #(
    .DATA_W(DW), .NREGS(NR), .CNT_W(CW)
  ) dut (
    .clk(clk), .i_reset(rst), .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtyp(input logic [4:0] s,
    input logic [4:0] t, input logic [4:0] d, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] ityp(input logic [5:0] o,
    input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
    return {o, s, t, im};
  endfunction

  task automatic drv(input logic [31:0] ins, input logic v);
    @(negedge clk);
    bus.i_instruction = ins;
    bus.i_valid = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_pc = 32'h0;
    bus.i_instruction = 32'h0;
    bus.i_valid = 1'b0;
    bus.i_wb_we = 1'b0;
    bus.i_wb_addr = 5'd0;
    bus.i_wb_data = '0;
    bus.i_exmem_regwrite = 1'b0;
    bus.i_exmem_memread = 1'b0;
    bus.i_exmem_rd = 5'd0;
    bus.i_exmem_data = '0;
    bus.i_hold = 1'b0;
    #2;
    chk("rst_valid", bus.o_ex_valid, 0);
    chk("rst_cnt", bus.o_stall_count, 0);
    chk("rst_regwrite", bus.o_ex_regwrite, 0);
    step();
    chk("rst_edge_valid", bus.o_ex_valid, 0);

    @(negedge clk);
    rst = 1'b0;
    bus.i_wb_we = 1'b1;
    bus.i_wb_addr = 5'd1;
    bus.i_wb_data = 32'd7;
    step();

    drv(rtyp(5, 1, 6, 6'h20), 1'b1);
    bus.i_wb_addr = 5'd5;
    bus.i_wb_data = 32'hDEADBEEF;
    #1;
    chk("add_pcw", bus.o_pc_write, 1);
    chk("add_ifw", bus.o_if_id_write, 1);
    chk("add_pcsrc", bus.o_pc_src, 0);
    step();
    chk("wt_valid", bus.o_ex_valid, 1);
    chk("wt_rsval", bus.o_ex_rs_val, 32'hDEADBEEF);
    chk("wt_rtval", bus.o_ex_rt_val, 7);
    chk("add_regwrite", bus.o_ex_regwrite, 1);
    chk("add_aluop", bus.o_ex_aluop, 0);
    chk("add_dst", bus.o_ex_dst, 6);

    drv(rtyp(5, 1, 2, 6'h22), 1'b1);
    bus.i_wb_we = 1'b0;
    step();
    chk("sub_aluop", bus.o_ex_aluop, 1);
    chk("sub_rsval", bus.o_ex_rs_val, 32'hDEADBEEF);

    drv(rtyp(1, 1, 4, 6'h3F), 1'b1);
    step();
    chk("badfn_aluop", bus.o_ex_aluop, 4'hF);
    chk("badfn_regwrite", bus.o_ex_regwrite, 0);
    chk("badfn_valid", bus.o_ex_valid, 1);

    drv(ityp(6'h08, 1, 3, 16'hFFFE), 1'b1);
    step();
    chk("addi_imm", bus.o_ex_imm, 32'hFFFFFFFE);
    chk("addi_alusrc", bus.o_ex_alusrc, 1);
    chk("addi_dst", bus.o_ex_dst, 3);
    chk("addi_regwrite", bus.o_ex_regwrite, 1);

    drv(ityp(6'h04, 3, 0, 16'h0001), 1'b1);
    #1;
    chk("brst_pcw", bus.o_pc_write, 0);
    chk("brst_ifw", bus.o_if_id_write, 0);
    chk("brst_pcsrc", bus.o_pc_src, 0);
    step();
    chk("brst_valid", bus.o_ex_valid, 0);
    chk("brst_cnt", bus.o_stall_count, 1);

    drv(32'h0, 1'b0);
    step();

    drv(ityp(6'h04, 1, 2, 16'hFFFF), 1'b1);
    bus.i_pc = 32'h100;
    bus.i_exmem_regwrite = 1'b1;
    bus.i_exmem_rd = 5'd2;
    bus.i_exmem_data = 32'd7;
    #1;
    chk("beq_pcsrc", bus.o_pc_src, 1);
    chk("beq_target", bus.o_target, 32'hFC);
    chk("beq_flush", bus.o_if_id_flush, 1);
    chk("beq_pcw", bus.o_pc_write, 1);
    step();
    chk("beq_bubble", bus.o_ex_valid, 0);

    drv(ityp(6'h05, 1, 2, 16'hFFFF), 1'b1);
    #1;
    chk("bne_pcsrc", bus.o_pc_src, 0);
    chk("bne_flush", bus.o_if_id_flush, 0);
    step();

    drv({6'h02, 26'd4}, 1'b1);
    bus.i_exmem_regwrite = 1'b0;
    bus.i_pc = 32'h40000010;
    #1;
    chk("j_target", bus.o_target, 32'h40000010);
    chk("j_pcsrc", bus.o_pc_src, 1);
    step();
    chk("j_bubble", bus.o_ex_valid, 0);

    drv(ityp(6'h23, 1, 3, 16'h0), 1'b1);
    step();
    chk("lw_memread", bus.o_ex_memread, 1);
    chk("lw_memtoreg", bus.o_ex_memtoreg, 1);
    chk("lw_rt", bus.o_ex_rt, 3);

    drv(rtyp(3, 1, 4, 6'h20), 1'b1);
    #1;
    chk("lu_pcw", bus.o_pc_write, 0);
    chk("lu_ifw", bus.o_if_id_write, 0);
    step();
    chk("lu_valid", bus.o_ex_valid, 0);
    chk("lu_cnt", bus.o_stall_count, 2);

    drv(ityp(6'h23, 1, 3, 16'h0), 1'b1);
    step();

    drv(rtyp(1, 3, 4, 6'h20), 1'b1);
    bus.i_hold = 1'b1;
    bus.i_wb_we = 1'b1;
    bus.i_wb_addr = 5'd7;
    bus.i_wb_data = 32'h55;
    #1;
    chk("hold_pcw", bus.o_pc_write, 0);
    chk("hold_ifw", bus.o_if_id_write, 0);
    chk("hold_pcsrc", bus.o_pc_src, 0);
    step();
    chk("hold_memread", bus.o_ex_memread, 1);
    chk("hold_valid", bus.o_ex_valid, 1);
    chk("hold_cnt", bus.o_stall_count, 2);

    @(negedge clk);
    bus.i_hold = 1'b0;
    bus.i_wb_we = 1'b0;
    #1;
    chk("lurt_pcw", bus.o_pc_write, 0);
    step();
    chk("lurt_cnt", bus.o_stall_count, 3);
    chk("lurt_valid", bus.o_ex_valid, 0);

    drv(rtyp(7, 0, 4, 6'h20), 1'b1);
    step();
    chk("holdwr_rsval", bus.o_ex_rs_val, 32'h55);

    drv(ityp(6'h23, 1, 3, 16'h0), 1'b1);
    step();
    drv(rtyp(3, 1, 4, 6'h20), 1'b1);
    step();
    chk("sat4_cnt", bus.o_stall_count, 3);

    drv(ityp(6'h23, 1, 3, 16'h0), 1'b1);
    step();
    drv(rtyp(3, 1, 4, 6'h20), 1'b1);
    step();
    chk("sat5_cnt", bus.o_stall_count, 3);

    drv(ityp(6'h23, 1, 3, 16'h0), 1'b1);
    step();
    drv(rtyp(3, 1, 4, 6'h20), 1'b1);
    #1;
    chk("mid_pcw", bus.o_pc_write, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", bus.o_ex_valid, 0);
    chk("arst_memread", bus.o_ex_memread, 0);
    chk("arst_rt", bus.o_ex_rt, 0);
    chk("arst_cnt", bus.o_stall_count, 0);
    step();
    chk("arst_edge_valid", bus.o_ex_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    drv(rtyp(0, 1, 4, 6'h20), 1'b1);
    bus.i_wb_we = 1'b1;
    bus.i_wb_addr = 5'd0;
    bus.i_wb_data = 32'h99;
    step();
    chk("r0_wt", bus.o_ex_rs_val, 0);
    chk("r1_cleared", bus.o_ex_rt_val, 0);

    drv(rtyp(0, 0, 4, 6'h20), 1'b1);
    bus.i_wb_we = 1'b0;
    step();
    chk("r0_stored", bus.o_ex_rs_val, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stage_decode_pipe.md
STAGE_DECODE_PIPE -- requirements
Module: stage_decode_pipe

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, register/operand width in bits (32 or 64); NREGS, 32, register count (power of 2, 2..32); CNT_W, 16, stall-counter width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock, all state on rising edge.
- i_reset  in  1  reset, asynchronous and active-high.
- i_pc  in  32  PC+4 of the instruction in IF/ID.
- i_instruction  in  32  IF/ID instruction word.
- i_valid  in  1  IF/ID holds a real instruction; 0 = bubble.
- i_wb_we, i_wb_addr, i_wb_data  in  1/5/DATA_W  writeback port.
- i_exmem_regwrite, i_exmem_memread, i_exmem_rd, i_exmem_data  in  1/1/5/DATA_W  EX/MEM stage state for branch forwarding.
- i_hold  in  1  downstream freeze.
- o_pc_write, o_if_id_write, o_if_id_flush  out  1 each  fetch control.
- o_pc_src  out  1  redirect fetch to o_target.
- o_target  out  32  branch/jump target.
- o_ex_valid, o_ex_regwrite, o_ex_memread, o_ex_memwrite, o_ex_memtoreg, o_ex_alusrc  out  1 each  registered ID/EX controls.
- o_ex_aluop  out  4  registered ALU operation.
- o_ex_rs_val, o_ex_rt_val, o_ex_imm  out  DATA_W each  registered operands and sign-extended immediate.
- o_ex_rs, o_ex_rt, o_ex_dst  out  5 each  registered register addresses.
- o_stall_count  out  CNT_W  saturating count of stall cycles.

Function
REQ-003 Register file SHALL hold NREGS x DATA_W entries; entry 0 SHALL always read 0, and writes to it SHALL be ignored; address bits above log2(NREGS) SHALL be ignored.
REQ-004 Reads SHALL be combinational with write-through: if i_wb_we and i_wb_addr equals the read address (nonzero), i_wb_data SHALL be returned in that same cycle.
REQ-005 Decoded opcodes SHALL be: 0x00 R-type (aluop from funct: 0x20 add=0, 0x22 sub=1, 0x24 and=2, 0x25 or=3, 0x2A slt=4, other=0xF with regwrite 0); 0x08 ADDI; 0x23 LW; 0x2B SW; 0x04 BEQ; 0x05 BNE; 0x02 J. Any other opcode SHALL decode as a bubble.
REQ-006 Immediate SHALL be instr[15:0] sign-extended to DATA_W; dst SHALL be rd for R-type and rt for ADDI/LW.
REQ-007 Load-use stall SHALL assert when o_ex_valid, o_ex_memread, o_ex_rt != 0, and o_ex_rt matches the current rs, or matches rt when the instruction reads rt (R-type, SW, BEQ, BNE).
REQ-008 Branch stall SHALL assert for BEQ/BNE when either source (nonzero) matches o_ex_dst with o_ex_regwrite, or matches i_exmem_rd with i_exmem_memread.
REQ-009 Branch operands SHALL take i_exmem_data when i_exmem_regwrite, !i_exmem_memread, and i_exmem_rd matches the source (nonzero); otherwise they SHALL take register file data.
REQ-010 On stall (REQ-007/008, i_valid=1): o_pc_write=0, o_if_id_write=0, and the ID/EX register SHALL load a bubble (all controls 0, o_ex_valid=0).
REQ-011 With no stall, a taken BEQ/BNE SHALL give o_pc_src=1, o_if_id_flush=1, o_target=i_pc+(imm<<2) (32-bit, wrap-around). J SHALL give the same with o_target={i_pc[31:28],instr[25:0],2'b00}. Branches and jumps SHALL enter ID/EX as bubbles.
REQ-012 i_hold=1 SHALL hold every ID/EX register and force o_pc_write=o_if_id_write=0 and o_pc_src=o_if_id_flush=0; register-file writes SHALL still occur; i_hold SHALL take precedence over stall.
REQ-013 ID/EX latency SHALL be one cycle; fetch-control outputs SHALL be combinational in the same cycle.
REQ-014 o_stall_count SHALL increment on every REQ-010 stall cycle and saturate at all-ones.

Reset
REQ-015 i_reset=1 SHALL immediately zero all register-file entries, all o_ex_* outputs, and o_stall_count, independent of clk.
REQ-016 After reset, ID/EX SHALL present a bubble until the first rising edge with i_reset=0.

Verification
REQ-017 Write-through: i_wb_we=1, addr=5, data=0xDEADBEEF, same cycle ADD rs=5 -> next cycle o_ex_rs_val=0xDEADBEEF.
REQ-018 Load-use: LW rt=3 in ID/EX, ADD rs=3 in ID -> o_pc_write=0, o_if_id_write=0, next o_ex_valid=0, o_stall_count=1.
REQ-019 BEQ forwarding: r1=7, EX/MEM ALU writes r2=7, BEQ r1,r2,imm=-1, i_pc=0x100 -> o_pc_src=1, o_target=0xFC, o_if_id_flush=1.
REQ-020 J with i_pc=0x40000010, target field=0x0000004 -> o_target=0x40000010.
REQ-021 Reset mid-stall: assert i_reset during a load-use stall -> all o_ex_* outputs and o_stall_count=0 immediately; write to r0 ignored.
REQ-022 Saturation: CNT_W=2, 5 stall cycles -> o_stall_count=3.
